// File: rtl/aline_pkg.sv
// ============================================================================
// Module : aline_pkg
// Shared state encoding and default sizes for the A-line buffer path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package aline_pkg;

    localparam int AL_ADDR_W   = 5;
    localparam int AL_DATA_W   = 8;
    localparam int AL_LINE_LEN = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        RD_ADDR = 3'd2,
        RD_WAIT = 3'd3,
        SEND    = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/aline_drain_fsm.sv
// ============================================================================
// Module : aline_drain_fsm
// Reads the stored A-line back one byte at a time and hands it to UART TX.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aline_drain_fsm
    import aline_pkg::*;
#(
    parameter int ADDR_W   = AL_ADDR_W,
    parameter int DATA_W   = AL_DATA_W,
    parameter int LINE_LEN = AL_LINE_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go_i,
    input  logic              tx_ready_i,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              tx_valid_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              addr_ld_o,
    output logic [ADDR_W-1:0] addr_nxt_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_LEN - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic                tx_valid_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                hs;

    assign hs         = (state_q == SEND) && tx_valid_q && tx_ready_i;
    assign last_o     = hs && (rd_ptr_q == LAST_IDX);
    // The next read address is issued on the handshake edge so RAM data is ready in RD_WAIT.
    assign addr_ld_o  = hs && (rd_ptr_q != LAST_IDX);
    assign addr_nxt_o = rd_ptr_q + ADDR_W'(1);
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go_i) begin
                        rd_ptr_q <= '0;
                        state_q  <= RD_ADDR;
                    end
                end
                RD_ADDR: state_q <= RD_WAIT;
                RD_WAIT: begin
                    tx_data_q  <= ram_dout_i;
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (hs) begin
                        tx_valid_q <= 1'b0;
                        if (rd_ptr_q == LAST_IDX) begin
                            state_q <= IDLE;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                            state_q  <= RD_ADDR;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/aline_buffer_ctrl.sv
// ============================================================================
// Module : aline_buffer_ctrl
// Captures one A-line into the storage RAM, then drains it to UART TX.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aline_buffer_ctrl
    import aline_pkg::*;
#(
    parameter int ADDR_W   = AL_ADDR_W,
    parameter int DATA_W   = AL_DATA_W,
    parameter int LINE_LEN = AL_LINE_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              cap_valid_i,
    input  logic [DATA_W-1:0] cap_data_i,
    input  logic              tx_ready_i,
    output logic              tx_valid_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    output logic              ram_wr_en_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic              clr_err_i
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_LEN - 1);

    // phase_q holds RD_ADDR for the whole drain; the sub-FSM tracks the finer steps.
    state_t              phase_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_din_q;
    logic                ram_wr_en_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                fill_end;
    logic                err_set;
    logic                drain_addr_ld;
    logic                drain_last;
    logic [ADDR_W-1:0]   drain_addr_nxt;

    assign fill_end = (phase_q == FILL) && ram_wr_en_q && (ram_addr_q == LAST_IDX);
    assign err_set  = (start_i && busy_q) ||
                      (cap_valid_i && ((phase_q == RD_ADDR) || (phase_q == DONE)));

    aline_drain_fsm #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LINE_LEN (LINE_LEN)
    ) u_drain (
        .clk        (clk),
        .rst_n      (rst_n),
        .go_i       (fill_end),
        .tx_ready_i (tx_ready_i),
        .ram_dout_i (ram_dout_i),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .addr_ld_o  (drain_addr_ld),
        .addr_nxt_o (drain_addr_nxt),
        .last_o     (drain_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= IDLE;
            wr_ptr_q    <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_wr_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (phase_q)
                IDLE: begin
                    if (start_i) begin
                        wr_ptr_q <= '0;
                        busy_q   <= 1'b1;
                        phase_q  <= FILL;
                    end
                end
                FILL: begin
                    // Once the final write is on the port, switch straight to reading address 0.
                    if (fill_end) begin
                        ram_wr_en_q <= 1'b0;
                        ram_addr_q  <= '0;
                        phase_q     <= RD_ADDR;
                    end else if (cap_valid_i) begin
                        ram_wr_en_q <= 1'b1;
                        ram_addr_q  <= wr_ptr_q;
                        ram_din_q   <= cap_data_i;
                        if (wr_ptr_q != LAST_IDX) begin
                            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                        end
                    end else begin
                        ram_wr_en_q <= 1'b0;
                    end
                end
                RD_ADDR: begin
                    if (drain_addr_ld) begin
                        ram_addr_q <= drain_addr_nxt;
                    end
                    if (drain_last) begin
                        done_q  <= 1'b1;
                        phase_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    phase_q <= IDLE;
                end
                default: phase_q <= IDLE;
            endcase

            if (err_set) begin
                err_q <= 1'b1;
            end else if (clr_err_i) begin
                err_q <= 1'b0;
            end
        end
    end

    assign ram_addr_o  = ram_addr_q;
    assign ram_din_o   = ram_din_q;
    assign ram_wr_en_o = ram_wr_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

`default_nettype wire
